// File: rtl/mem_access_stage.sv
// mem_access_stage: RV32 memory-access stage with the M->W pipeline register.
// Issues loads/stores over a req/ack handshake to a variable-latency data
// memory, aligns and extends load data, generates store byte enables, and
// holds the pipeline with StallM while an access is outstanding.
// Optional feature: define MEM_TIMEOUT_EN to abort accesses that wait
// TIMEOUT cycles without an ack; the abort sets the sticky bus_err flag.
module mem_access_stage #(
  parameter int unsigned TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        validM,
  input  logic        RegWriteM,
  input  logic [1:0]  ResultSrcM,
  input  logic        MemWriteM,
  input  logic [2:0]  funct3M,
  input  logic [31:0] ALUResultM,
  input  logic [31:0] WriteDataM,
  input  logic [4:0]  RdM,
  input  logic [31:0] PCPlus4M,
  output logic        StallM,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [31:0] dmem_addr,
  output logic [3:0]  dmem_be,
  output logic [31:0] dmem_wdata,
  input  logic [31:0] dmem_rdata,
  input  logic        dmem_ack,
  output logic        RegWriteW,
  output logic [1:0]  ResultSrcW,
  output logic [31:0] ALUResultW,
  output logic [31:0] ReadDataW,
  output logic [4:0]  RdW,
  output logic [31:0] PCPlus4W,
  output logic        validW,
  output logic        bus_err
);

  typedef enum logic [0:0] {
    S_IDLE = 1'b0,
    S_WAIT = 1'b1
  } state_t;

  state_t      state_q, state_d;
  logic        memop;
  logic        req;
  logic        stall;
  logic        abort;
  logic [3:0]  be;
  logic [31:0] wdata;
  logic [7:0]  ld_byte;
  logic [15:0] ld_half;
  logic [31:0] ld_data;

  logic        regwrite_w_q;
  logic [1:0]  resultsrc_w_q;
  logic [31:0] aluresult_w_q;
  logic [31:0] readdata_w_q;
  logic [4:0]  rd_w_q;
  logic [31:0] pcplus4_w_q;
  logic        valid_w_q;

`ifdef MEM_TIMEOUT_EN
  localparam int unsigned CW = $clog2(TIMEOUT);
  logic [CW-1:0] cnt_q, cnt_d;
  logic          bus_err_q, bus_err_d;
`else
  logic unused_timeout;
  assign unused_timeout = (TIMEOUT < 2);
`endif

  // Instruction needs the data memory this cycle.
  always_comb memop = validM & (MemWriteM | (ResultSrcM == 2'b01));

  // Handshake FSM: next state, request and stall.
  always_comb begin
    state_d = state_q;
    req     = 1'b0;
    stall   = 1'b0;
    abort   = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (memop) begin
          req = 1'b1;
          if (!dmem_ack) begin
            stall   = 1'b1;
            state_d = S_WAIT;
          end
        end
      end
      S_WAIT: begin
        req = 1'b1;
        if (dmem_ack) begin
          state_d = S_IDLE;
        end else begin
          stall = 1'b1;
`ifdef MEM_TIMEOUT_EN
          if (cnt_q == CW'(TIMEOUT - 1)) begin
            req     = 1'b0;
            stall   = 1'b0;
            abort   = 1'b1;
            state_d = S_IDLE;
          end
`endif
        end
      end
      default: state_d = S_IDLE;
    endcase
    // Outputs must read 0 for the whole reset assertion, even though the
    // M inputs may still present a memory op.
    if (reset) begin
      req   = 1'b0;
      stall = 1'b0;
      abort = 1'b0;
    end
  end

  // FSM state register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

`ifdef MEM_TIMEOUT_EN
  // Wait-cycle counter and sticky timeout flag.
  always_comb begin
    cnt_d     = cnt_q;
    bus_err_d = bus_err_q | abort;
    if (state_q == S_IDLE && state_d == S_WAIT) cnt_d = '0;
    else if (state_q == S_WAIT)                 cnt_d = cnt_q + 1'b1;
  end

  // Timeout counter and flag registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q     <= '0;
      bus_err_q <= 1'b0;
    end else begin
      cnt_q     <= cnt_d;
      bus_err_q <= bus_err_d;
    end
  end

  assign bus_err = bus_err_q;
`else
  assign bus_err = 1'b0;
`endif

  // Store byte enables and lane-replicated store data.
  always_comb begin
    be    = 4'b1111;
    wdata = WriteDataM;
    if (MemWriteM) begin
      case (funct3M[1:0])
        2'b00: begin
          be    = 4'b0001 << ALUResultM[1:0];
          wdata = {4{WriteDataM[7:0]}};
        end
        2'b01: begin
          be    = 4'b0011 << {ALUResultM[1], 1'b0};
          wdata = {2{WriteDataM[15:0]}};
        end
        default: ;
      endcase
    end
    if (!req) be = '0;
  end

  // Load lane select and sign/zero extension.
  always_comb begin
    case (ALUResultM[1:0])
      2'b00:   ld_byte = dmem_rdata[7:0];
      2'b01:   ld_byte = dmem_rdata[15:8];
      2'b10:   ld_byte = dmem_rdata[23:16];
      default: ld_byte = dmem_rdata[31:24];
    endcase
    ld_half = ALUResultM[1] ? dmem_rdata[31:16] : dmem_rdata[15:0];
    case (funct3M)
      3'b000:  ld_data = {{24{ld_byte[7]}}, ld_byte};
      3'b100:  ld_data = {24'h0, ld_byte};
      3'b001:  ld_data = {{16{ld_half[15]}}, ld_half};
      3'b101:  ld_data = {16'h0, ld_half};
      default: ld_data = dmem_rdata;
    endcase
  end

  assign StallM     = stall;
  assign dmem_req   = req;
  assign dmem_we    = req & MemWriteM;
  assign dmem_addr  = {ALUResultM[31:2], 2'b00};
  assign dmem_be    = be;
  assign dmem_wdata = wdata;

  // M->W pipeline register: bubble while stalled, else capture M fields.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      regwrite_w_q  <= 1'b0;
      resultsrc_w_q <= '0;
      aluresult_w_q <= '0;
      readdata_w_q  <= '0;
      rd_w_q        <= '0;
      pcplus4_w_q   <= '0;
      valid_w_q     <= 1'b0;
    end else if (stall) begin
      regwrite_w_q  <= 1'b0;
      valid_w_q     <= 1'b0;
    end else begin
      regwrite_w_q  <= RegWriteM & validM & ~abort;
      resultsrc_w_q <= ResultSrcM;
      aluresult_w_q <= ALUResultM;
      readdata_w_q  <= abort ? '0 : ld_data;
      rd_w_q        <= RdM;
      pcplus4_w_q   <= PCPlus4M;
      valid_w_q     <= validM;
    end
  end

  assign RegWriteW  = regwrite_w_q;
  assign ResultSrcW = resultsrc_w_q;
  assign ALUResultW = aluresult_w_q;
  assign ReadDataW  = readdata_w_q;
  assign RdW        = rd_w_q;
  assign PCPlus4W   = pcplus4_w_q;
  assign validW     = valid_w_q;

endmodule

// File: tb/tb_mem_access_stage.sv
// Directed testbench for mem_access_stage. Inputs change 1 time unit after
// the rising edge; combinational outputs are checked 1 unit later and
// registered outputs 1 unit after the following rising edge.
// Timeout vectors are built only when MEM_TIMEOUT_EN is defined.
module tb_mem_access_stage;

  logic        clk = 1'b0;
  logic        reset;
  logic        validM;
  logic        RegWriteM;
  logic [1:0]  ResultSrcM;
  logic        MemWriteM;
  logic [2:0]  funct3M;
  logic [31:0] ALUResultM;
  logic [31:0] WriteDataM;
  logic [4:0]  RdM;
  logic [31:0] PCPlus4M;
  logic        StallM;
  logic        dmem_req;
  logic        dmem_we;
  logic [31:0] dmem_addr;
  logic [3:0]  dmem_be;
  logic [31:0] dmem_wdata;
  logic [31:0] dmem_rdata;
  logic        dmem_ack;
  logic        RegWriteW;
  logic [1:0]  ResultSrcW;
  logic [31:0] ALUResultW;
  logic [31:0] ReadDataW;
  logic [4:0]  RdW;
  logic [31:0] PCPlus4W;
  logic        validW;
  logic        bus_err;

  int n_vec  = 0;
  int n_miss = 0;
  int n_stall;

  always #5 clk = ~clk;

  mem_access_stage #(.TIMEOUT(16)) dut (
    .clk        (clk),
    .reset      (reset),
    .validM     (validM),
    .RegWriteM  (RegWriteM),
    .ResultSrcM (ResultSrcM),
    .MemWriteM  (MemWriteM),
    .funct3M    (funct3M),
    .ALUResultM (ALUResultM),
    .WriteDataM (WriteDataM),
    .RdM        (RdM),
    .PCPlus4M   (PCPlus4M),
    .StallM     (StallM),
    .dmem_req   (dmem_req),
    .dmem_we    (dmem_we),
    .dmem_addr  (dmem_addr),
    .dmem_be    (dmem_be),
    .dmem_wdata (dmem_wdata),
    .dmem_rdata (dmem_rdata),
    .dmem_ack   (dmem_ack),
    .RegWriteW  (RegWriteW),
    .ResultSrcW (ResultSrcW),
    .ALUResultW (ALUResultW),
    .ReadDataW  (ReadDataW),
    .RdW        (RdW),
    .PCPlus4W   (PCPlus4W),
    .validW     (validW),
    .bus_err    (bus_err)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic set_m(input logic v, input logic rw, input logic [1:0] rs, input logic mw,
                       input logic [2:0] f3, input logic [31:0] a, input logic [31:0] wd,
                       input logic [4:0] rd);
    validM     = v;
    RegWriteM  = rw;
    ResultSrcM = rs;
    MemWriteM  = mw;
    funct3M    = f3;
    ALUResultM = a;
    WriteDataM = wd;
    RdM        = rd;
    PCPlus4M   = a ^ 32'h1000_0000;
  endtask

  task automatic idle();
    set_m(1'b0, 1'b0, 2'b00, 1'b0, 3'b000, 32'h0, 32'h0, 5'd0);
    dmem_ack = 1'b0;
  endtask

  // Load with `waits` unacked cycles before the ack cycle.
  task automatic do_load(input string tag, input logic [2:0] f3, input logic [31:0] a,
                         input logic [31:0] rdata, input int unsigned waits,
                         input logic [31:0] exp);
    set_m(1'b1, 1'b1, 2'b01, 1'b0, f3, a, 32'h0, 5'd7);
    dmem_rdata = rdata;
    dmem_ack   = 1'b0;
    for (int unsigned i = 0; i < waits; i++) begin
      settle();
      check({tag, " stall"}, StallM, 1);
      check({tag, " req held"}, dmem_req, 1);
      tick();
      check({tag, " bubble"}, validW, 0);
    end
    dmem_ack = 1'b1;
    settle();
    check({tag, " stall@ack"}, StallM, 0);
    check({tag, " req"}, dmem_req, 1);
    check({tag, " we"}, dmem_we, 0);
    check({tag, " be"}, dmem_be, 4'b1111);
    check({tag, " addr"}, dmem_addr, {a[31:2], 2'b00});
    tick();
    check({tag, " data"}, ReadDataW, exp);
    check({tag, " validW"}, validW, 1);
    check({tag, " RegWriteW"}, RegWriteW, 1);
    check({tag, " RdW"}, RdW, 7);
    idle();
  endtask

  // Store acked in the same cycle.
  task automatic do_store(input string tag, input logic [2:0] f3, input logic [31:0] a,
                          input logic [31:0] rs2, input logic [3:0] exp_be,
                          input logic [31:0] exp_wd);
    set_m(1'b1, 1'b0, 2'b00, 1'b1, f3, a, rs2, 5'd0);
    dmem_ack = 1'b1;
    settle();
    check({tag, " req"}, dmem_req, 1);
    check({tag, " we"}, dmem_we, 1);
    check({tag, " be"}, dmem_be, exp_be);
    check({tag, " wdata"}, dmem_wdata, exp_wd);
    check({tag, " addr"}, dmem_addr, {a[31:2], 2'b00});
    check({tag, " stall"}, StallM, 0);
    tick();
    check({tag, " RegWriteW"}, RegWriteW, 0);
    check({tag, " validW"}, validW, 1);
    idle();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset      = 1'b1;
    dmem_rdata = 32'h0;
    idle();
    #3;
    check("rst StallM", StallM, 0);
    check("rst req", dmem_req, 0);
    check("rst we", dmem_we, 0);
    check("rst be", dmem_be, 4'b0000);
    check("rst validW", validW, 0);
    check("rst RegWriteW", RegWriteW, 0);
    check("rst ReadDataW", ReadDataW, 0);
    check("rst bus_err", bus_err, 0);
    tick();
    reset = 1'b0;
    tick();

    do_load("LW zero-wait", 3'b010, 32'h0000_0100, 32'hDEAD_BEEF, 0, 32'hDEAD_BEEF);
    do_load("LB 0x103",     3'b000, 32'h0000_0103, 32'h80FF_0000, 3, 32'hFFFF_FF80);
    do_load("LBU 0x103",    3'b100, 32'h0000_0103, 32'h80FF_0000, 3, 32'h0000_0080);
    do_load("LH 0x102",     3'b001, 32'h0000_0102, 32'h80FF_0000, 1, 32'hFFFF_80FF);
    do_load("LHU 0x102",    3'b101, 32'h0000_0102, 32'h80FF_0000, 2, 32'h0000_80FF);
    do_load("LB 0x102",     3'b000, 32'h0000_0102, 32'h80FF_0000, 0, 32'hFFFF_FFFF);
    do_load("LHU 0x100",    3'b101, 32'h0000_0100, 32'h80FF_0000, 0, 32'h0000_0000);

    do_store("SB 0x201", 3'b000, 32'h0000_0201, 32'h1234_5678, 4'b0010, 32'h7878_7878);
    do_store("SH 0x202", 3'b001, 32'h0000_0202, 32'h1234_5678, 4'b1100, 32'h5678_5678);
    do_store("SW 0x204", 3'b010, 32'h0000_0204, 32'h1234_5678, 4'b1111, 32'h1234_5678);

    // ALU op with a stray ack: no request, no stall, fields captured.
    set_m(1'b1, 1'b1, 2'b00, 1'b0, 3'b000, 32'hCAFE_0001, 32'h0, 5'd9);
    dmem_ack = 1'b1;
    settle();
    check("ALU req", dmem_req, 0);
    check("ALU stall", StallM, 0);
    check("ALU be", dmem_be, 4'b0000);
    tick();
    check("ALU ALUResultW", ALUResultW, 32'hCAFE_0001);
    check("ALU PCPlus4W", PCPlus4W, 32'hDAFE_0001);
    check("ALU RegWriteW", RegWriteW, 1);
    check("ALU RdW", RdW, 9);
    check("ALU ResultSrcW", ResultSrcW, 2'b00);
    check("ALU validW", validW, 1);

    // Bubble with RegWriteM set must not write back; stray ack ignored.
    set_m(1'b0, 1'b1, 2'b01, 1'b0, 3'b010, 32'h0000_0300, 32'h0, 5'd3);
    dmem_ack = 1'b1;
    settle();
    check("bubble req", dmem_req, 0);
    tick();
    check("bubble RegWriteW", RegWriteW, 0);
    check("bubble validW", validW, 0);
    idle();

    // Reset two cycles into an unacked load.
    set_m(1'b1, 1'b1, 2'b01, 1'b0, 3'b010, 32'h0000_0300, 32'h0, 5'd5);
    dmem_ack = 1'b0;
    tick();
    tick();
    settle();
    check("pre-rst stall", StallM, 1);
    reset = 1'b1;
    settle();
    check("midrst StallM", StallM, 0);
    check("midrst req", dmem_req, 0);
    check("midrst validW", validW, 0);
    check("midrst be", dmem_be, 4'b0000);
    tick();
    reset = 1'b0;
    do_load("LW after rst", 3'b010, 32'h0000_0100, 32'h0123_4567, 0, 32'h0123_4567);

`ifdef MEM_TIMEOUT_EN
    // Load never acked: 16 stall cycles, then abort.
    set_m(1'b1, 1'b1, 2'b01, 1'b0, 3'b010, 32'h0000_0400, 32'h0, 5'd4);
    dmem_rdata = 32'h5555_5555;
    dmem_ack   = 1'b0;
    n_stall    = 0;
    for (int i = 0; i < 40; i++) begin
      settle();
      if (!StallM) break;
      n_stall++;
      tick();
    end
    check("TO stall cycles", n_stall, 16);
    check("TO req drop", dmem_req, 0);
    tick();
    check("TO bus_err", bus_err, 1);
    check("TO RegWriteW", RegWriteW, 0);
    check("TO ReadDataW", ReadDataW, 0);
    idle();
    tick();
    check("TO bus_err sticky", bus_err, 1);
    reset = 1'b1;
    settle();
    check("TO bus_err rst", bus_err, 0);
    tick();
    reset = 1'b0;

    // Ack in the same cycle the counter reaches TIMEOUT-1: ack wins.
    set_m(1'b1, 1'b1, 2'b01, 1'b0, 3'b010, 32'h0000_0404, 32'h0, 5'd6);
    dmem_rdata = 32'hA5A5_A5A5;
    for (int i = 0; i < 16; i++) begin
      settle();
      check("TOack stall", StallM, 1);
      tick();
    end
    dmem_ack = 1'b1;
    settle();
    check("TOack stall@ack", StallM, 0);
    check("TOack req", dmem_req, 1);
    tick();
    check("TOack data", ReadDataW, 32'hA5A5_A5A5);
    check("TOack RegWriteW", RegWriteW, 1);
    check("TOack bus_err", bus_err, 0);
    idle();
`endif

    tick();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
